mc_ctrl_fsm: RTL

//  Main control FSM of the multicycle MIPS core. Sequences the shared datapath: PC, IR, register

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 72 +++++++
 rtl/mc_ctrl_fsm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// datapath mux selects and the packed control word driven onto the datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_RD    = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WR    = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_TRAP      = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // States that stall on the memory handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the current state into the datapath control word.
// Handshake qualification of the FETCH strobes is applied by the top.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Per-state control word; anything not set stays at the idle value.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core: state register, next-state
// logic, memory-ready qualification of strobes and the sticky illegal flag.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   ready_s;
    logic   done_s;
    ctrl_t  dec_s;
    ctrl_t  ctrl_s;

    // Without a handshake every memory access completes in one cycle.
    assign ready_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (dec_s)
    );

    // Next-state selection and end-of-instruction detection.
    always_comb begin
        state_d = state_q;
        done_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (ready_s) state_d = ST_DECODE;
                else         state_d = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default: begin
                        if (TRAP_ILLEGAL) begin
                            state_d = ST_TRAP;
                        end else begin
                            state_d = ST_FETCH;
                            done_s  = 1'b1;
                        end
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW) state_d = ST_MEM_RD;
                else                 state_d = ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (ready_s) state_d = ST_MEM_WB;
                else         state_d = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (ready_s) begin
                    state_d = ST_FETCH;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                done_s  = 1'b1;
            end
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
    end

    // Illegal flag latches on the transition into TRAP and stays until reset.
    always_comb begin
        if (state_d == ST_TRAP) illegal_d = 1'b1;
        else                    illegal_d = illegal_q;
    end

    // State and illegal-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset gating and handshake qualification of the FETCH strobes.
    always_comb begin
        ctrl_s = dec_s;
        if (!rst_n) begin
            ctrl_s = CTRL_IDLE;
        end else if (is_wait_state(state_q) && (state_q == ST_FETCH)) begin
            ctrl_s.ir_write = ready_s;
            ctrl_s.pc_write = ready_s;
        end else begin
            ctrl_s = dec_s;
        end
    end

    assign pc_write      = ctrl_s.pc_write;
    assign pc_write_cond = ctrl_s.pc_write_cond;
    assign i_or_d        = ctrl_s.i_or_d;
    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign ir_write      = ctrl_s.ir_write;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign reg_dst       = ctrl_s.reg_dst;
    assign reg_write     = ctrl_s.reg_write;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign alu_op        = ctrl_s.alu_op;
    assign pc_source     = ctrl_s.pc_source;
    assign instr_done    = done_s & rst_n;
    assign illegal_op    = illegal_q;
    assign state         = state_q;

endmodule
